// File: rtl/traffic_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_timer: 1-second prescaled 4-bit countdown timer, saturates at 0.  |
// | Optional macro TIMER_FAST_SIM_EN forces 4 clk cycles per second tick.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module traffic_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PRESCALE_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timer_load,
  input  logic       timer_en,
  input  logic [3:0] timer_init,
  output logic [3:0] timer_out,
  output logic       expired,
  output logic       sec_tick
);

`ifdef TIMER_FAST_SIM_EN
  localparam int c_eff_ticks = 4;
`else
  localparam int c_eff_ticks = TICKS_PER_SEC;
`endif

  localparam logic [PRESCALE_W-1:0] c_term = PRESCALE_W'(c_eff_ticks - 1);

  // IDLE/COUNTING is purely a decode of timer_out; there is no state register.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_t;

  state_t                w_state;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] w_prescale_nxt;
  logic [3:0]            w_count_nxt;
  logic                  w_tick_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prescale <= '0;
      timer_out  <= 4'd0;
      sec_tick   <= 1'b0;
    end else begin
      r_prescale <= w_prescale_nxt;
      timer_out  <= w_count_nxt;
      sec_tick   <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state        = (timer_out == 4'd0) ? IDLE : COUNTING;
    w_prescale_nxt = r_prescale;
    w_count_nxt    = timer_out;
    w_tick_nxt     = 1'b0;
    if (timer_load) begin
      // Load wins over a pending terminal count: no decrement this cycle.
      w_prescale_nxt = '0;
      w_count_nxt    = timer_init;
    end else if (timer_en) begin
      if (r_prescale == c_term) begin
        w_prescale_nxt = '0;
        w_tick_nxt     = 1'b1;
        if (w_state == COUNTING) begin
          w_count_nxt = timer_out - 4'd1;
        end
      end else begin
        w_prescale_nxt = r_prescale + PRESCALE_W'(1);
      end
    end
  end

  assign expired = (timer_out == 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_traffic_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_traffic_timer: directed self-checking bench, TICKS_PER_SEC=4.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_traffic_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       timer_load;
  logic       timer_en;
  logic [3:0] timer_init;
  logic [3:0] timer_out;
  logic       expired;
  logic       sec_tick;

  int checks   = 0;
  int failures = 0;

  traffic_timer #(
    .TICKS_PER_SEC (4),
    .PRESCALE_W    (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .timer_load (timer_load),
    .timer_en   (timer_en),
    .timer_init (timer_init),
    .timer_out  (timer_out),
    .expired    (expired),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; sample/drive 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; timer_load = 1'b0; timer_en = 1'b0; timer_init = 4'd0;

    // Reset
    step(2);
    chk4("rst_out", timer_out, 4'd0);
    chk1("rst_expired", expired, 1'b1);
    chk1("rst_tick", sec_tick, 1'b0);
    rst = 1'b1;

    // Load 5 and count down with saturation
    timer_load = 1'b1; timer_init = 4'd5; timer_en = 1'b1;
    step(1);
    chk4("load5_out", timer_out, 4'd5);
    chk1("load5_tick", sec_tick, 1'b0);
    timer_load = 1'b0;
    step(3);
    chk4("pre_first_dec", timer_out, 4'd5);
    step(1);
    chk4("first_dec", timer_out, 4'd4);
    chk1("first_dec_tick", sec_tick, 1'b1);
    step(1);
    chk1("tick_one_cycle", sec_tick, 1'b0);
    step(14);
    chk4("before_zero", timer_out, 4'd1);
    chk1("before_zero_exp", expired, 1'b0);
    step(1);
    chk4("zero_out", timer_out, 4'd0);
    chk1("zero_expired", expired, 1'b1);
    chk1("zero_tick", sec_tick, 1'b1);
    step(4);
    chk4("saturate_out", timer_out, 4'd0);
    chk1("saturate_tick", sec_tick, 1'b1);

    // Pause / resume
    timer_load = 1'b1; timer_init = 4'd10;
    step(1);
    chk4("load10_out", timer_out, 4'd10);
    timer_load = 1'b0;
    step(6);
    chk4("pause_pre", timer_out, 4'd9);
    timer_en = 1'b0;
    step(10);
    chk4("pause_hold", timer_out, 4'd9);
    chk1("pause_tick", sec_tick, 1'b0);
    timer_en = 1'b1;
    step(1);
    chk4("resume_1", timer_out, 4'd9);
    step(1);
    chk4("resume_2", timer_out, 4'd8);
    chk1("resume_tick", sec_tick, 1'b1);

    // Load over enable at terminal prescale
    step(3);
    timer_load = 1'b1; timer_init = 4'd15;
    step(1);
    chk4("load15_out", timer_out, 4'd15);
    chk1("load15_tick", sec_tick, 1'b0);
    timer_load = 1'b0;
    step(3);
    chk4("load15_hold", timer_out, 4'd15);
    step(1);
    chk4("load15_dec", timer_out, 4'd14);

    // Load 0
    timer_load = 1'b1; timer_init = 4'd0;
    step(1);
    chk4("load0_out", timer_out, 4'd0);
    chk1("load0_expired", expired, 1'b1);

    // Load 12, count to 7, reset mid-second at terminal prescale
    timer_init = 4'd12;
    step(1);
    chk4("load12_out", timer_out, 4'd12);
    timer_load = 1'b0;
    step(20);
    chk4("count_to_7", timer_out, 4'd7);
    step(3);
    rst = 1'b0;
    step(1);
    chk4("midrst_out", timer_out, 4'd0);
    chk1("midrst_tick", sec_tick, 1'b0);
    chk1("midrst_expired", expired, 1'b1);
    rst = 1'b1;
    step(3);
    chk1("postrst_no_tick", sec_tick, 1'b0);
    step(1);
    chk1("postrst_tick", sec_tick, 1'b1);
    chk4("postrst_out", timer_out, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Countdown timer driven directly by traffic_light_controller; produces its timer_out.
- Divides the system clock into a 1-second tick and decrements a 4-bit seconds counter.
- Supports load, enable/pause, and saturate-at-zero.
- Controller compares timer_out to 0 to advance states (15 s, 10 s and 5 s phases).

Parameters:
- TICKS_PER_SEC, 50_000_000: clk cycles per second tick; legal range >= 2.
- PRESCALE_W, 26: prescaler width; must satisfy 2^PRESCALE_W > TICKS_PER_SEC.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low (reset when rst==0 at a rising clk edge).
- timer_load  input  1  load timer_init into the counter this cycle.
- timer_en  input  1  count enable; 0 freezes prescaler and counter.
- timer_init  input  4  load value, in seconds (0-15).
- timer_out  output  4  current remaining seconds, registered.
- expired  output  1  timer_out==4'd0; combinational decode of the register.
- sec_tick  output  1  one-cycle pulse when a decrement occurs (or would occur at 0).

Behaviour:
- Reset (rst==0 at posedge): timer_out=0, prescaler=0, sec_tick=0. expired then reads 1.
- Priority per cycle: reset > timer_load > timer_en > hold.
- Load:
  - timer_out<=timer_init and prescaler<=0 on the next edge, regardless of timer_en.
  - sec_tick<=0.
  - timer_init visible on timer_out one cycle after timer_load.
- Enabled (timer_en=1, timer_load=0):
  - If prescaler==TICKS_PER_SEC-1: prescaler<=0, sec_tick<=1, and timer_out<=timer_out-1 if timer_out!=0.
  - Otherwise prescaler<=prescaler+1, sec_tick<=0.
  - First decrement lands exactly TICKS_PER_SEC cycles after the load edge, provided timer_en is continuously high.
- Saturation: at timer_out==0 the counter holds at 0 and never wraps to 15. Prescaler keeps running while enabled; sec_tick still pulses each second.
- Pause: timer_en=0 holds both prescaler and timer_out; sec_tick<=0. Re-enabling resumes mid-second with no prescaler loss.
- Load of 0: timer_out=0 next cycle; expired=1 immediately.
- Load while running: new value overrides and the prescaler restarts. No decrement occurs that cycle, even if the prescaler was at its terminal value.
- Reset mid-count: next edge forces the reset values; no residual tick.
- State machine: IDLE (timer_out==0) and COUNTING (timer_out!=0), implicit in timer_out. No extra state register.
- Arithmetic: prescaler is an unsigned PRESCALE_W-bit counter; timer_out is unsigned 4-bit. Decrement is guarded, so there is no underflow.

Optional Feature:
- Macro TIMER_FAST_SIM_EN.
- Defined: effective ticks-per-second forced to 4, regardless of TICKS_PER_SEC, for simulation and board demo of the full controller cycle.
- Undefined: TICKS_PER_SEC used as given.
- All other behaviour is identical in both cases.

Test Plan (bench uses TICKS_PER_SEC=4):
- Reset: rst=0 for 2 cycles, then 1 -> timer_out=0, expired=1, sec_tick=0.
- Load and count: timer_load=1, timer_init=5, then timer_en=1 held.
  - timer_out=5 one cycle after load.
  - Decrements to 4 four cycles after the load edge, then to 0 after 20 cycles.
  - expired rises with 0; timer_out holds 0 thereafter; sec_tick keeps pulsing every 4 cycles.
- Pause: load 10, enable for 6 cycles, drop timer_en for 10 cycles, re-enable.
  - timer_out=9 frozen during the pause.
  - Next decrement (to 8) occurs 2 enabled cycles after resume.
- Load-over-enable: while counting at prescaler==3, assert timer_load with timer_init=15 and timer_en=1.
  - timer_out=15 next cycle with no decrement that cycle.
  - Next decrement 4 cycles later.
- Load 0 and reset mid-count:
  - Load 0 -> expired=1 next cycle.
  - Load 12, count to 7, pulse rst=0 -> timer_out=0 next edge and no sec_tick.
